// File: rtl/clint_pkg.sv
// Shared CLINT definitions: address map, mip bit positions, reset constants, bus FSM states.
package clint_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TIME_W = 64;

  localparam logic [ADDR_W-1:0] MSIP_OFF        = 16'h0000;
  localparam logic [ADDR_W-1:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [ADDR_W-1:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [ADDR_W-1:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [ADDR_W-1:0] MTIME_HI_OFF    = 16'hBFFC;

  // Bit positions inside the mip image, shared with the CSR block
  localparam int unsigned MTIP_BIT = 7;
  localparam int unsigned MSIP_BIT = 3;

  localparam logic [TIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: pulses tick once every TICK_DIV clock cycles.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned    CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tick = (r_count == CNT_MAX);

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-outstanding bus,
// producing the mip image (MTIP, MSIP) for the CSR file.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1,
  parameter bit          BASE_CHECK = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ack,
  output logic [DATA_W-1:0] mip_out,
  output logic [TIME_W-1:0] mtime_o
);

  // Unmapped reads return zero under either BASE_CHECK setting
  localparam logic [DATA_W-1:0] UNMAPPED_RDATA = BASE_CHECK ? 32'h0 : 32'h0;

  bus_state_e        r_state;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ack;
  logic [TIME_W-1:0] r_mtime;
  logic [TIME_W-1:0] r_mtimecmp;
  logic              r_msip;
  logic              r_mtip;

  bus_req_t          w_req;
  logic              w_tick;
  logic              w_accept;
  logic              w_wr;
  logic [DATA_W-1:0] w_rd_data;

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_req    = {bus_we, bus_addr, bus_wdata};
  assign w_accept = (r_state == IDLE) && bus_sel;
  assign w_wr     = w_accept && w_req.we;

  // Read mux over pre-write register values
  always_comb begin
    w_rd_data = UNMAPPED_RDATA;
    case (w_req.addr)
      MSIP_OFF:        w_rd_data = {31'b0, r_msip};
      MTIMECMP_LO_OFF: w_rd_data = r_mtimecmp[31:0];
      MTIMECMP_HI_OFF: w_rd_data = r_mtimecmp[63:32];
      MTIME_LO_OFF:    w_rd_data = r_mtime[31:0];
      MTIME_HI_OFF:    w_rd_data = r_mtime[63:32];
      default:         w_rd_data = UNMAPPED_RDATA;
    endcase
  end

  // Bus FSM: accept in IDLE, ack for one cycle in ACK, then back to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          if (bus_sel) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            if (!w_req.we) begin
              r_rdata <= w_rd_data;
            end
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // mtime: a bus write to either half wins over the tick increment
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtime <= '0;
    end else if (w_wr && (w_req.addr == MTIME_LO_OFF)) begin
      r_mtime[31:0] <= w_req.wdata;
    end else if (w_wr && (w_req.addr == MTIME_HI_OFF)) begin
      r_mtime[63:32] <= w_req.wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + TIME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtimecmp <= MTIMECMP_RST;
      r_msip     <= 1'b0;
      r_mtip     <= 1'b0;
    end else begin
      if (w_wr && (w_req.addr == MTIMECMP_LO_OFF)) begin
        r_mtimecmp[31:0] <= w_req.wdata;
      end
      if (w_wr && (w_req.addr == MTIMECMP_HI_OFF)) begin
        r_mtimecmp[63:32] <= w_req.wdata;
      end
      if (w_wr && (w_req.addr == MSIP_OFF)) begin
        r_msip <= w_req.wdata[0];
      end
      r_mtip <= (r_mtime >= r_mtimecmp);
    end
  end

  assign bus_rdata = r_rdata;
  assign bus_ack   = r_ack;
  assign mtime_o   = r_mtime;
  assign mip_out   = {24'b0, r_mtip, 3'b0, r_msip, 3'b0};

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: reference model, rdata scoreboard, vector table
// and hand sequences for compare, wrap, prescaler and reset corner cases.
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [15:0] bus_addr = 16'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] mip_out;
  logic [63:0] mtime_o;

  logic        d_sel = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = 16'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] d_mip;
  logic [63:0] d_mtime;

  always #5 clk = ~clk;

  clint_timer #(.TICK_DIV(1), .BASE_CHECK(1'b0)) u_dut (
    .clk(clk), .reset(reset), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .mip_out(mip_out), .mtime_o(mtime_o)
  );

  clint_timer #(.TICK_DIV(4), .BASE_CHECK(1'b1)) u_div4 (
    .clk(clk), .reset(reset), .bus_sel(d_sel), .bus_we(d_we),
    .bus_addr(d_addr), .bus_wdata(d_wdata), .bus_rdata(d_rdata),
    .bus_ack(d_ack), .mip_out(d_mip), .mtime_o(d_mtime)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rd;
    logic [31:0] exp;
  } sb_t;
  sb_t q[$];
  sb_t e;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_mip;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model of the main instance (TICK_DIV=1), advanced on every clock edge
  logic [63:0] m_time, m_cmp, nt, nc;
  logic        m_msip, m_mtip, m_busy, acc;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_time = 64'h0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip = 1'b0;  m_mtip = 1'b0; m_busy = 1'b0;
    end else begin
      acc = bus_sel && !m_busy;
      nt  = m_time + 64'd1;
      nc  = m_cmp;
      if (acc && bus_we) begin
        case (bus_addr)
          16'hBFF8: nt = {m_time[63:32], bus_wdata};
          16'hBFFC: nt = {bus_wdata, m_time[31:0]};
          16'h4000: nc = {m_cmp[63:32], bus_wdata};
          16'h4004: nc = {bus_wdata, m_cmp[31:0]};
          16'h0000: m_msip = bus_wdata[0];
          default: ;
        endcase
      end
      m_mtip = (m_time >= m_cmp);
      m_time = nt;
      m_cmp  = nc;
      m_busy = acc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_mtime", mtime_o, m_time);
      check("model_mip", 64'(mip_out), 64'({24'h0, m_mtip, 3'b0, m_msip, 3'b0}));
      if (bus_ack) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected_ack: got ack with empty scoreboard, expected no ack");
        end else begin
          e = q.pop_front();
          if (e.rd) check("sb_rdata", 64'(bus_rdata), 64'(e.exp));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start(input bit we, input logic [15:0] a, input logic [31:0] d, input logic [31:0] exp);
    q.push_back('{rd: !we, exp: exp});
    bus_sel = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
  endtask

  task automatic txn(input bit we, input logic [15:0] a, input logic [31:0] d, input logic [31:0] exp);
    start(we, a, d, exp);
    step();
    bus_sel = 1'b0;
    check("txn_ack", 64'(bus_ack), 64'd1);
    step();
    check("txn_ack_low", 64'(bus_ack), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'h4000, 32'h0000_1234, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 16'h4000, 32'h0,         32'h0000_1234, 32'h0};
    tbl[2]  = '{1'b0, 16'h4004, 32'h0,         32'h0,         32'h0};
    tbl[3]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 32'h0,         32'h8};
    tbl[4]  = '{1'b0, 16'h0000, 32'h0,         32'h1,         32'h8};
    tbl[5]  = '{1'b1, 16'h4004, 32'h0000_ABCD, 32'h0,         32'h8};
    tbl[6]  = '{1'b0, 16'h4004, 32'h0,         32'h0000_ABCD, 32'h8};
    tbl[7]  = '{1'b1, 16'h0008, 32'hDEAD_BEEF, 32'h0,         32'h8};
    tbl[8]  = '{1'b0, 16'h0008, 32'h0,         32'h0,         32'h8};
    tbl[9]  = '{1'b0, 16'h1234, 32'h0,         32'h0,         32'h8};
    tbl[10] = '{1'b1, 16'h0000, 32'h0000_0002, 32'h0,         32'h0};
    tbl[11] = '{1'b0, 16'h0000, 32'h0,         32'h0,         32'h0};

    // Reset state
    repeat (3) step();
    check("rst_ack",   64'(bus_ack),   64'd0);
    check("rst_rdata", 64'(bus_rdata), 64'd0);
    check("rst_mip",   64'(mip_out),   64'd0);
    check("rst_mtime", mtime_o,        64'd0);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Free run and read mtime_lo
    repeat (10) step();
    check("t1_mtime", mtime_o, 64'd10);
    check("t1_mip",   64'(mip_out), 64'd0);
    txn(1'b0, 16'hBFF8, 32'h0, 32'd10);
    txn(1'b0, 16'h4004, 32'h0, 32'hFFFF_FFFF);

    // Compare against mtimecmp=20, then raise it to 100
    txn(1'b1, 16'h4004, 32'h0, 32'h0);
    txn(1'b1, 16'h4000, 32'd20, 32'h0);
    for (int i = 0; i < 100 && mtime_o != 64'd20; i++) step();
    check("t2_reach20", mtime_o, 64'd20);
    check("t2_mtip_pre", 64'(mip_out[7]), 64'd0);
    step();
    check("t2_mtip_rise", 64'(mip_out[7]), 64'd1);
    start(1'b1, 16'h4000, 32'd100, 32'h0);
    step();
    bus_sel = 1'b0;
    check("t2_mtip_wr_edge", 64'(mip_out[7]), 64'd1);
    step();
    check("t2_mtip_drop", 64'(mip_out[7]), 64'd0);

    // Register access vectors
    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d_mip", i), 64'(mip_out), 64'(tbl[i].exp_mip));
    end
    txn(1'b0, 16'h4000, 32'h0, 32'h0000_1234);
    step(); step();
    check("rdata_hold", 64'(bus_rdata), 64'h1234);

    // 64-bit wrap with mtimecmp at max
    txn(1'b1, 16'h4004, 32'hFFFF_FFFF, 32'h0);
    txn(1'b1, 16'h4000, 32'hFFFF_FFFF, 32'h0);
    txn(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 32'h0);
    start(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 32'h0);
    step();
    bus_sel = 1'b0;
    check("t4_mtime_fe", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t4_mtip_fe", 64'(mip_out[7]), 64'd0);
    step();
    check("t4_mtime_max", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t4_mtip_max", 64'(mip_out[7]), 64'd0);
    step();
    check("t4_mtime_wrap", mtime_o, 64'd0);
    check("t4_mtip_set", 64'(mip_out[7]), 64'd1);
    step();
    check("t4_mtip_clr", 64'(mip_out[7]), 64'd0);
    txn(1'b0, 16'hBFFC, 32'h0, 32'h0);

    // Prescaler: TICK_DIV=4 instance, write mtime_lo on a tick edge
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (3) step();
    check("t5_no_tick", d_mtime, 64'd0);
    step();
    check("t5_first_tick", d_mtime, 64'd1);
    repeat (3) step();
    d_sel = 1'b1; d_we = 1'b1; d_addr = 16'hBFF8; d_wdata = 32'h100;
    step();
    d_sel = 1'b0;
    check("t5_wr_ack", 64'(d_ack), 64'd1);
    check("t5_wr_hold", d_mtime, 64'h100);
    repeat (3) step();
    check("t5_hold3", d_mtime, 64'h100);
    step();
    check("t5_next_tick", d_mtime, 64'h101);

    // Held bus_sel on an unmapped address, then reset during ACK
    txn(1'b0, 16'h4000, 32'h0, 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) q.push_back('{rd: 1'b1, exp: 32'h0});
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 16'h1234;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("t6_ack%0d", k), 64'(bus_ack), 64'(k % 2));
    end
    reset = 1'b1; bus_we = 1'b1; bus_addr = 16'h0000; bus_wdata = 32'h1;
    step();
    check("t6_rst_ack",   64'(bus_ack),   64'd0);
    check("t6_rst_rdata", 64'(bus_rdata), 64'd0);
    check("t6_rst_mtime", mtime_o,        64'd0);
    step();
    reset = 1'b0; bus_sel = 1'b0;
    step();
    check("t6_msip_discard", 64'(mip_out), 64'd0);
    check("t6_ack_idle",     64'(bus_ack), 64'd0);
    check("sb_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
